// File: rtl/vote_counter_n.sv
// rtl/vote_counter_n.sv - ballot-box vote counter with per-candidate tallies and result display
module vote_counter_n #(
  parameter int N_CAND  = 4,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 64,
  localparam int IDX_W  = $clog2(N_CAND + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ballot,
  input  logic [N_CAND-1:0] sel,
  input  logic              total,
  input  logic              close,
  input  logic              result,
  output logic [CNT_W-1:0]  disp,
  output logic [IDX_W-1:0]  disp_idx,
  output logic              armed,
  output logic              closed,
  output logic              tie,
  output logic              sat
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_TOT = IDX_W'(N_CAND + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_OPEN, S_ARMED, S_WAIT_REL, S_CLOSED} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   cnt [N_CAND];
  logic [CNT_W-1:0]   tot, inv;
  logic               clear_q, ballot_q, total_q, close_q, result_q;
  logic               clear_ev, ballot_ev, total_ev, close_ev, result_ev;
  logic               sel_one, sel_many;
  logic               do_clear, do_vote, do_inv;
  logic [IDX_W-1:0]   win;
  logic [CNT_W-1:0]   max_v;
  int                 n_max;

  // Edge registers reset high so a button held through reset gives no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_q  <= 1'b1;
      ballot_q <= 1'b1;
      total_q  <= 1'b1;
      close_q  <= 1'b1;
      result_q <= 1'b1;
    end else begin
      clear_q  <= clear;
      ballot_q <= ballot;
      total_q  <= total;
      close_q  <= close;
      result_q <= result;
    end
  end

  assign clear_ev  = clear  & ~clear_q;
  assign ballot_ev = ballot & ~ballot_q;
  assign total_ev  = total  & ~total_q;
  assign close_ev  = close  & ~close_q;
  assign result_ev = result & ~result_q;

  assign sel_one  = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign sel_many = (sel != '0) && !sel_one;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OPEN;
      timer    <= '0;
      disp_idx <= IDX_TOT;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      disp_idx <= idx_nxt;
    end
  end

  // Only the highest-priority event acts in a given cycle.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = disp_idx;
    do_clear  = 1'b0;
    do_vote   = 1'b0;
    do_inv    = 1'b0;
    if (clear_ev) begin
      do_clear  = 1'b1;
      state_nxt = S_OPEN;
      timer_nxt = '0;
      idx_nxt   = IDX_TOT;
    end else if (close_ev) begin
      state_nxt = S_CLOSED;
      timer_nxt = '0;
    end else if (total_ev) begin
      idx_nxt = IDX_TOT;
    end else if (result_ev) begin
      if (state == S_CLOSED)
        idx_nxt = (disp_idx == IDX_TOT) ? '0 : disp_idx + 1'b1;
    end else begin
      case (state)
        S_OPEN: begin
          if (ballot_ev) begin
            state_nxt = S_ARMED;
            timer_nxt = TMR_W'(TIMEOUT);
          end
        end
        S_ARMED: begin
          if (sel_one || sel_many) begin
            do_vote   = sel_one;
            do_inv    = sel_many;
            state_nxt = S_WAIT_REL;
            timer_nxt = '0;
          end else if (timer <= TMR_W'(1)) begin
            state_nxt = S_OPEN;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
        S_WAIT_REL: begin
          if (sel == '0)
            state_nxt = S_OPEN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || do_clear) begin
      for (int i = 0; i < N_CAND; i++)
        cnt[i] <= '0;
      tot <= '0;
      inv <= '0;
      sat <= 1'b0;
    end else begin
      if (do_vote) begin
        for (int i = 0; i < N_CAND; i++) begin
          if (sel[i]) begin
            if (cnt[i] == CNT_MAX) sat <= 1'b1;
            else                   cnt[i] <= cnt[i] + 1'b1;
          end
        end
        if (tot == CNT_MAX) sat <= 1'b1;
        else                tot <= tot + 1'b1;
      end
      if (do_inv) begin
        if (inv == CNT_MAX) sat <= 1'b1;
        else                inv <= inv + 1'b1;
      end
    end
  end

  // Strict greater-than keeps the lowest index on equal counts.
  always_comb begin
    win   = '0;
    max_v = cnt[0];
    n_max = 0;
    for (int i = 1; i < N_CAND; i++) begin
      if (cnt[i] > max_v) begin
        max_v = cnt[i];
        win   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_CAND; i++)
      if (cnt[i] == max_v) n_max = n_max + 1;
    tie = (n_max >= 2) && (max_v != '0);
  end

  always_comb begin
    disp = '0;
    for (int i = 0; i < N_CAND; i++)
      if (disp_idx == IDX_W'(i)) disp = cnt[i];
    if (disp_idx == IDX_W'(N_CAND))     disp = inv;
    if (disp_idx == IDX_W'(N_CAND + 1)) disp = CNT_W'(win);
    if (disp_idx == IDX_TOT)            disp = tot;
  end

  assign armed  = (state == S_ARMED);
  assign closed = (state == S_CLOSED);

endmodule
